// File: rtl/mix_columns_seq.sv
// rtl/mix_columns_seq.sv - sequential AES (Inv)MixColumns engine, COLS_PER_CYCLE columns per clock
// Optional macro MIX_COLUMNS_INV_EN: when defined, in_inv selects InvMixColumns per state.
module mix_columns_seq #(
    parameter int COLS_PER_CYCLE = 4,
    parameter int TAG_W          = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [3:0][3:0][7:0]   in_data,
    input  logic [TAG_W-1:0]       in_tag,
    input  logic                   in_inv,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0][3:0][7:0]   out_data,
    output logic [TAG_W-1:0]       out_tag,
    output logic                   busy
);

    if (!((COLS_PER_CYCLE == 1) || (COLS_PER_CYCLE == 2) || (COLS_PER_CYCLE == 4)) || (TAG_W < 1)) begin : g_bad_param
        $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4 and TAG_W >= 1");
    end

    // Counter step and the col_cnt value seen in the final RUN cycle (both wrap in 2 bits)
    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE % 4);
    localparam logic [1:0] LAST = 2'((4 - COLS_PER_CYCLE) % 4);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [1:0]            col_cnt_q, col_cnt_d;
    logic [3:0][3:0][7:0]  src_q, src_d;
    logic [TAG_W-1:0]      src_tag_q, src_tag_d;
    logic [3:0][3:0][7:0]  res_q, res_d;
    logic [TAG_W-1:0]      out_tag_q, out_tag_d;
    logic                  accept;
    logic [COLS_PER_CYCLE-1:0][3:0][7:0] mix_out;
`ifdef MIX_COLUMNS_INV_EN
    logic                  inv_q, inv_d;
`else
    logic                  unused_inv;
    assign unused_inv = in_inv;
`endif

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    // Forward circulant (02,03,01,01) on one column, bytes indexed by row
    function automatic logic [3:0][7:0] mix_fwd(input logic [3:0][7:0] a);
        logic [3:0][7:0] m2, m3, r;
        logic [1:0]      j;
        for (int i = 0; i < 4; i++) begin
            m2[i] = xtime(a[i]);
            m3[i] = m2[i] ^ a[i];
        end
        for (int i = 0; i < 4; i++) begin
            j    = 2'(i);
            r[j] = m2[j] ^ m3[j + 2'd1] ^ a[j + 2'd2] ^ a[j + 2'd3];
        end
        return r;
    endfunction

`ifdef MIX_COLUMNS_INV_EN
    // Inverse circulant (0E,0B,0D,09) built from repeated xtime
    function automatic logic [3:0][7:0] mix_inv(input logic [3:0][7:0] a);
        logic [3:0][7:0] x2, x4, x8, m9, mb, md, me, r;
        logic [1:0]      j;
        for (int i = 0; i < 4; i++) begin
            x2[i] = xtime(a[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ a[i];
            mb[i] = x8[i] ^ x2[i] ^ a[i];
            md[i] = x8[i] ^ x4[i] ^ a[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        for (int i = 0; i < 4; i++) begin
            j    = 2'(i);
            r[j] = me[j] ^ mb[j + 2'd1] ^ md[j + 2'd2] ^ m9[j + 2'd3];
        end
        return r;
    endfunction
`endif

    assign in_ready  = rst_n & ((state_q == S_IDLE) | ((state_q == S_DONE) & out_ready));
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_q == S_DONE);
    assign busy      = (state_q == S_RUN) | (state_q == S_DONE);
    assign out_data  = res_q;
    assign out_tag   = out_tag_q;

    // Mix the COLS_PER_CYCLE source columns starting at col_cnt_q
    always_comb begin
        mix_out = '0;
        for (int k = 0; k < COLS_PER_CYCLE; k++) begin
`ifdef MIX_COLUMNS_INV_EN
            mix_out[k] = inv_q ? mix_inv(src_q[col_cnt_q + 2'(k)]) : mix_fwd(src_q[col_cnt_q + 2'(k)]);
`else
            mix_out[k] = mix_fwd(src_q[col_cnt_q + 2'(k)]);
`endif
        end
    end

    // Next-state logic: capture on accept, fill result columns during RUN
    always_comb begin
        state_d   = state_q;
        col_cnt_d = col_cnt_q;
        src_d     = src_q;
        src_tag_d = src_tag_q;
        res_d     = res_q;
        out_tag_d = out_tag_q;
`ifdef MIX_COLUMNS_INV_EN
        inv_d     = inv_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int k = 0; k < COLS_PER_CYCLE; k++) begin
                    res_d[col_cnt_q + 2'(k)] = mix_out[k];
                end
                out_tag_d = src_tag_q;
                col_cnt_d = col_cnt_q + STEP;
                if (col_cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = in_valid ? S_RUN : S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Back-to-back capture in DONE shares this path with IDLE
        if (accept) begin
            src_d     = in_data;
            src_tag_d = in_tag;
            col_cnt_d = 2'd0;
`ifdef MIX_COLUMNS_INV_EN
            inv_d     = in_inv;
`endif
        end
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            col_cnt_q <= 2'd0;
            src_q     <= '0;
            src_tag_q <= '0;
            res_q     <= '0;
            out_tag_q <= '0;
`ifdef MIX_COLUMNS_INV_EN
            inv_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            col_cnt_q <= col_cnt_d;
            src_q     <= src_d;
            src_tag_q <= src_tag_d;
            res_q     <= res_d;
            out_tag_q <= out_tag_d;
`ifdef MIX_COLUMNS_INV_EN
            inv_q     <= inv_d;
`endif
        end
    end

endmodule

// File: tb/tb_mix_columns_seq.sv
// tb/tb_mix_columns_seq.sv - bench for mix_columns_seq against a GF(2^8) matrix reference model
module tb_mix_columns_seq;

    typedef logic [3:0][3:0][7:0] state_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, in_inv, out_valid, out_ready, busy;
    state_t      in_data, out_data;
    logic [3:0]  in_tag, out_tag;

    logic        iv_x, or_x, ird2, ird4, ov2, ov4, bz2, bz4;
    state_t      id_x, od2, od4;
    logic [3:0]  it_x, ot2, ot4;

    int          n_checks = 0;
    int          n_errs   = 0;
    int          n_out    = 0;
    logic        fire_in  = 1'b0;
    logic        hold_prev = 1'b0;
    state_t      prev_data;
    logic [3:0]  prev_tag;
    logic [131:0] exp_q[$];

    always #5 clk = ~clk;

    mix_columns_seq #(.COLS_PER_CYCLE(1), .TAG_W(4)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_tag(in_tag), .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_tag(out_tag), .busy(busy));

    mix_columns_seq #(.COLS_PER_CYCLE(2), .TAG_W(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(ird2), .in_data(id_x),
        .in_tag(it_x), .in_inv(1'b0), .out_valid(ov2), .out_ready(or_x),
        .out_data(od2), .out_tag(ot2), .busy(bz2));

    mix_columns_seq #(.COLS_PER_CYCLE(4), .TAG_W(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv_x), .in_ready(ird4), .in_data(id_x),
        .in_tag(it_x), .in_inv(1'b0), .out_valid(ov4), .out_ready(or_x),
        .out_data(od4), .out_tag(ot4), .busy(bz4));

    task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Shift-and-add GF(2^8) multiply
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x, y;
        p = 8'h00; x = a; y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Matrix form: r[c][i] = XOR_j coef[(j-i) mod 4] * a[c][j]
    function automatic state_t ref_mix(input state_t s, input logic inv);
        logic [7:0] coef [4];
        logic [7:0] acc;
        state_t     r;
        if (inv) coef = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
        for (int c = 0; c < 4; c++)
            for (int i = 0; i < 4; i++) begin
                acc = 8'h00;
                for (int j = 0; j < 4; j++) acc = acc ^ gmul(coef[(j - i + 4) % 4], s[c][j]);
                r[c][i] = acc;
            end
        return r;
    endfunction

    function automatic logic eff_inv(input logic inv);
`ifdef MIX_COLUMNS_INV_EN
        return inv;
`else
        return 1'b0 & inv;
`endif
    endfunction

    // Columns given as {row0,row1,row2,row3}
    function automatic state_t mk(input logic [31:0] w0, input logic [31:0] w1,
                                  input logic [31:0] w2, input logic [31:0] w3);
        logic [31:0] w [4];
        state_t      s;
        w = '{w0, w1, w2, w3};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) s[c][r] = w[c][31 - 8*r -: 8];
        return s;
    endfunction

    function automatic state_t rnd_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: predict on input handshake, compare on output handshake, check holds
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            hold_prev = 1'b0;
            fire_in   = 1'b0;
        end else begin
            fire_in = in_valid && in_ready;
            if (hold_prev)
                check("hold", 160'({out_valid, out_tag, out_data}), 160'({1'b1, prev_tag, prev_data}));
            if (fire_in) exp_q.push_back({in_tag, ref_mix(in_data, eff_inv(in_inv))});
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out", 160'(1), 160'(0));
                end else begin
                    logic [131:0] e;
                    e = exp_q.pop_front();
                    check("sb_data", 160'(out_data), 160'(e[127:0]));
                    check("sb_tag", 160'(out_tag), 160'(e[131:128]));
                    n_out++;
                end
            end
            hold_prev = out_valid && !out_ready;
            prev_data = out_data;
            prev_tag  = out_tag;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input state_t d, input logic [3:0] t, input logic inv);
        int n;
        in_valid = 1'b1; in_data = d; in_tag = t; in_inv = inv;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) check("send_timeout", 160'(0), 160'(1));
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 20) begin
            step();
            lat++;
        end
    endtask

    task automatic run_one(input state_t d, input logic [3:0] t, input logic inv, output state_t res);
        int lat;
        out_ready = 1'b0;
        send(d, t, inv);
        wait_out(lat);
        check("run_lat", 160'(lat), 160'(4));
        res = out_data;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        state_t fwd_in, fwd_exp, mixed_in, mixed_exp, r0, r1, r2, r2_exp;
        int     lat, lat2, lat4, sent, cyc, n_out0;
        state_t c2, c4;

        fwd_in    = mk(32'hdb135345, 32'hdb135345, 32'hdb135345, 32'hdb135345);
        fwd_exp   = mk(32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc, 32'h8e4da1bc);
        mixed_in  = mk(32'hf20a225c, 32'h01010101, 32'hc6c6c6c6, 32'hd4d4d4d5);
        mixed_exp = mk(32'h9fdc589d, 32'h01010101, 32'hc6c6c6c6, 32'hd5d5d7d6);

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_tag = '0; in_inv = 1'b0; out_ready = 1'b0;
        iv_x = 1'b0; or_x = 1'b0; id_x = '0; it_x = '0;
        repeat (3) step();
        check("rst_out_valid", 160'(out_valid), 160'(0));
        check("rst_busy", 160'(busy), 160'(0));
        check("rst_in_ready", 160'(in_ready), 160'(0));
        check("rst_out_data", 160'(out_data), 160'(0));
        check("rst_out_tag", 160'(out_tag), 160'(0));
        rst_n = 1'b1;
        #1;
        check("idle_in_ready", 160'(in_ready), 160'(1));

        // Forward vector, latency, then backpressure hold
        send(fwd_in, 4'h3, 1'b0);
        wait_out(lat);
        check("fwd_lat", 160'(lat), 160'(4));
        check("fwd_data", 160'(out_data), 160'(fwd_exp));
        check("fwd_tag", 160'(out_tag), 160'(4'h3));
        check("fwd_busy", 160'(busy), 160'(1));
        repeat (10) begin
            step();
            check("bp_in_ready", 160'(in_ready), 160'(0));
        end
        in_valid = 1'b1; in_data = mixed_in; in_tag = 4'hA; in_inv = 1'b0; out_ready = 1'b1;
        #1;
        check("b2b_in_ready", 160'(in_ready), 160'(1));
        step();
        in_valid = 1'b0; out_ready = 1'b0;
        wait_out(lat);
        check("b2b_lat", 160'(lat), 160'(4));
        check("mixed_data", 160'(out_data), 160'(mixed_exp));
        check("mixed_tag", 160'(out_tag), 160'(4'hA));
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;

        // Inverse selection and round trip
        run_one(fwd_exp, 4'h5, 1'b1, r0);
`ifdef MIX_COLUMNS_INV_EN
        check("inv_vec", 160'(r0), 160'(fwd_in));
`else
        check("inv_ignored", 160'(r0), 160'(ref_mix(fwd_exp, 1'b0)));
`endif
        r1 = rnd_state();
        run_one(r1, 4'h6, 1'b0, r2);
        run_one(r2, 4'h7, 1'b1, r0);
`ifdef MIX_COLUMNS_INV_EN
        r2_exp = r1;
`else
        r2_exp = ref_mix(r2, 1'b0);
`endif
        check("round_trip", 160'(r0), 160'(r2_exp));

        // Wider instances: latency N and data
        iv_x = 1'b1; id_x = fwd_in; it_x = 4'h1;
        step();
        iv_x = 1'b0;
        lat2 = -1; lat4 = -1; c2 = '0; c4 = '0;
        for (int k = 0; k < 8; k++) begin
            if (ov2 && lat2 < 0) begin lat2 = k; c2 = od2; end
            if (ov4 && lat4 < 0) begin lat4 = k; c4 = od4; end
            step();
        end
        check("cpc2_lat", 160'(lat2), 160'(2));
        check("cpc4_lat", 160'(lat4), 160'(1));
        check("cpc2_data", 160'(c2), 160'(fwd_exp));
        check("cpc4_data", 160'(c4), 160'(fwd_exp));
        check("cpc4_tag", 160'(ot4), 160'(4'h1));
        or_x = 1'b1;
        step();

        // Reset mid-RUN with col_cnt at 2
        out_ready = 1'b0;
        send(rnd_state(), 4'h9, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 160'(out_valid), 160'(0));
        check("midrst_busy", 160'(busy), 160'(0));
        check("midrst_in_ready", 160'(in_ready), 160'(0));
        step();
        step();
        rst_n = 1'b1;
        #1;
        check("postrst_in_ready", 160'(in_ready), 160'(1));
        out_ready = 1'b1;
        repeat (8) begin
            step();
            check("postrst_no_out", 160'(out_valid), 160'(0));
        end

        // Random streaming
        sent = 0; cyc = 0; n_out0 = n_out;
        while ((sent < 1000 || exp_q.size() != 0 || in_valid) && cyc < 40000) begin
            step();
            cyc++;
            if (in_valid && fire_in) begin
                sent++;
                in_valid = 1'b0;
            end
            if (!in_valid) begin
                in_data = rnd_state();
                in_tag  = 4'($urandom);
                in_inv  = 1'($urandom);
                if (sent < 1000 && $urandom_range(0, 3) != 0) in_valid = 1'b1;
            end
            out_ready = ($urandom_range(0, 2) != 0);
        end
        check("stream_done", 160'(sent == 1000 && exp_q.size() == 0), 160'(1));
        check("stream_count", 160'(n_out - n_out0), 160'(1000));

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
